// File: rtl/dev_bridge.sv
// dev_bridge: CPU-side bridge onto two timer responders.
// Decodes single load/store requests and registers timer IRQs into hwint.
module dev_bridge #(
    parameter logic [31:0] T0_BASE = 32'h0000_7F00,
    parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [29:0] dev_addr,
    output logic [31:0] dev_wdata,
    output logic [31:0] dev_pc,
    output logic        dev_we0,
    output logic        dev_we1,
    input  logic [31:0] dev0_rdata,
    input  logic [31:0] dev1_rdata,
    input  logic        irq0,
    input  logic        irq1,
    output logic [5:0]  hwint
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic        lat_we;
    logic [29:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;
    logic        lat_fault;
    logic        lat_sel;
    logic [31:0] rdata_q;
    logic [1:0]  irq_q;

    logic [31:0] off0;
    logic [31:0] off1;
    logic        aligned;
    logic        hit0;
    logic        hit1;
    logic        dec_fault;

    // Unsigned offset compare also rejects addresses below the base.
    assign off0    = cpu_addr - T0_BASE;
    assign off1    = cpu_addr - T1_BASE;
    assign aligned = (cpu_addr[1:0] == 2'b00);
    assign hit0    = aligned && (off0 <= 32'd8);
    assign hit1    = aligned && (off1 <= 32'd8);

    assign dec_fault = !(hit0 || hit1)
                     || (cpu_we && hit0 && (off0 == 32'd8))
                     || (cpu_we && hit1 && (off1 == 32'd8));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (cpu_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_pc    <= '0;
            lat_fault <= 1'b0;
            lat_sel   <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= '0;
        end else begin
            irq_q <= {irq1, irq0};
            if (state == IDLE && cpu_req) begin
                lat_we    <= cpu_we;
                lat_addr  <= cpu_addr[31:2];
                lat_wdata <= cpu_wdata;
                lat_pc    <= cpu_pc;
                lat_fault <= dec_fault;
                lat_sel   <= !hit0;
            end
            if (state == ACCESS) begin
                if (lat_we || lat_fault) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= lat_sel ? dev1_rdata : dev0_rdata;
                end
            end
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        cpu_err   = 1'b0;
        dev_we0   = 1'b0;
        dev_we1   = 1'b0;
        dev_addr  = lat_addr;
        dev_wdata = lat_wdata;
        dev_pc    = lat_pc;
        unique case (state)
            ACCESS: begin
                dev_we0 = lat_we && !lat_fault && !lat_sel;
                dev_we1 = lat_we && !lat_fault && lat_sel;
            end
            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = rdata_q;
                cpu_err   = lat_fault;
            end
            default: ;
        endcase
    end

    assign hwint = {4'b0000, irq_q};

endmodule

// File: tb/tb_dev_bridge.sv
// tb_dev_bridge: randomized bench for dev_bridge with a transaction-level
// reference model of the address map, strobes, read data and faults.
module tb_dev_bridge;

    localparam logic [31:0] T0 = 32'h0000_7F00;
    localparam logic [31:0] T1 = 32'h0000_7F10;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_pc;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [29:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [31:0] dev_pc;
    logic        dev_we0;
    logic        dev_we1;
    logic [31:0] dev0_rdata;
    logic [31:0] dev1_rdata;
    logic        irq0;
    logic        irq1;
    logic [5:0]  hwint;

    logic [31:0] key0;
    logic [31:0] key1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dev_bridge #(.T0_BASE(T0), .T1_BASE(T1)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_pc     (cpu_pc),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .dev_addr   (dev_addr),
        .dev_wdata  (dev_wdata),
        .dev_pc     (dev_pc),
        .dev_we0    (dev_we0),
        .dev_we1    (dev_we1),
        .dev0_rdata (dev0_rdata),
        .dev1_rdata (dev1_rdata),
        .irq0       (irq0),
        .irq1       (irq1),
        .hwint      (hwint)
    );

    // Timer read data: each device returns a keyed function of the word address.
    function automatic logic [31:0] dev_val(input logic sel,
                                            input logic [29:0] wa);
        return {2'b00, wa} ^ (sel ? key1 : key0);
    endfunction

    assign dev0_rdata = dev_val(1'b0, dev_addr);
    assign dev1_rdata = dev_val(1'b1, dev_addr);

    typedef struct packed {
        logic        we0_a;
        logic        we1_a;
        logic        rdy_a;
        logic        we0_r;
        logic        we1_r;
        logic        rdy_r;
        logic        rdy_i;
        logic        err;
        logic [29:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] dpc;
        logic [31:0] rdata;
    } obs_t;

    function automatic obs_t model(input logic we, input logic [31:0] a,
                                   input logic [31:0] wd,
                                   input logic [31:0] pc);
        obs_t e;
        longint unsigned o0;
        longint unsigned o1;
        bit al;
        bit h0;
        bit h1;
        bit flt;
        o0  = longint'(a) - longint'(T0);
        o1  = longint'(a) - longint'(T1);
        al  = (a % 4) == 0;
        h0  = al && (o0 <= 8);
        h1  = al && (o1 <= 8);
        flt = !(h0 || h1) || (we && ((h0 && o0 == 8) || (h1 && o1 == 8)));
        e        = '0;
        e.we0_a  = we && !flt && h0;
        e.we1_a  = we && !flt && !h0 && h1;
        e.rdy_r  = 1'b1;
        e.err    = flt;
        e.daddr  = 30'(a / 4);
        e.dwdata = wd;
        e.dpc    = pc;
        if (!we && !flt) e.rdata = dev_val(!h0, 30'(a / 4));
        return e;
    endfunction

    task automatic run_txn(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] pc,
                           output obs_t o);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_pc    = pc;
        @(negedge clk);
        o.we0_a  = dev_we0;
        o.we1_a  = dev_we1;
        o.rdy_a  = cpu_ready;
        o.daddr  = dev_addr;
        o.dwdata = dev_wdata;
        o.dpc    = dev_pc;
        cpu_req  = 1'b0;
        @(negedge clk);
        o.we0_r = dev_we0;
        o.we1_r = dev_we1;
        o.rdy_r = cpu_ready;
        o.rdata = cpu_rdata;
        o.err   = cpu_err;
        @(negedge clk);
        o.rdy_i = cpu_ready;
    endtask

    task automatic test_reset();
        logic [167:0] outs;
        reset = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_pc = '0;
        irq0 = 1'b0;
        irq1 = 1'b0;
        repeat (2) @(negedge clk);
        outs = {cpu_ready, cpu_rdata, cpu_err, dev_we0, dev_we1,
                dev_addr, dev_wdata, dev_pc, hwint};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        cpu_req  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = T0;
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_ready, dev_we0} !== 2'b00) begin
                errors++;
                $display("FAIL reset_drops_req[%0d] got=%b exp=00",
                         i, {cpu_ready, dev_we0});
            end
        end
    endtask

    task automatic test_store_load();
        obs_t o;
        obs_t e;
        run_txn(1'b1, 32'h7F00, 32'h9, 32'h400, o);
        e = model(1'b1, 32'h7F00, 32'h9, 32'h400);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL store_t0 got=%h exp=%h", o, e);
        end
        checks++;
        if (o.daddr !== 30'h1FC0 || o.we0_a !== 1'b1) begin
            errors++;
            $display("FAIL store_t0_addr got=%h/%b exp=1fc0/1",
                     o.daddr, o.we0_a);
        end
        run_txn(1'b0, 32'h7F00, 32'h0, 32'h404, o);
        e = model(1'b0, 32'h7F00, 32'h0, 32'h404);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL load_t0 got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_timer1_store();
        obs_t o;
        obs_t e;
        run_txn(1'b1, 32'h7F14, 32'h64, 32'h408, o);
        e = model(1'b1, 32'h7F14, 32'h64, 32'h408);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL store_t1 got=%h exp=%h", o, e);
        end
        checks++;
        if ({o.we0_a, o.we1_a, o.daddr} !== {2'b01, 30'h1FC5}) begin
            errors++;
            $display("FAIL store_t1_strobe got=%b%b/%h exp=01/1fc5",
                     o.we0_a, o.we1_a, o.daddr);
        end
    endtask

    task automatic test_faults();
        obs_t o;
        obs_t e;
        logic [31:0] fa [4];
        logic        fw [4];
        fa = '{32'h7F08, 32'h7F0C, 32'h7F02, 32'h3000};
        fw = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_txn(fw[i], fa[i], 32'hDEAD_0000 + i, 32'h500, o);
            e = model(fw[i], fa[i], 32'hDEAD_0000 + i, 32'h500);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fault[%0d] got=%h exp=%h", i, o, e);
            end
            checks++;
            if ({o.we0_a, o.we1_a, o.rdy_r, o.err, o.rdata} !==
                {4'b0011, 32'h0}) begin
                errors++;
                $display("FAIL fault_flags[%0d] got=%b%b%b%b/%h exp=0011/0",
                         i, o.we0_a, o.we1_a, o.rdy_r, o.err, o.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [3];
        obs_t e;
        int k;
        qa = '{32'h7F00, 32'h7F14, 32'h7F08};
        k = 0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = qa[0];
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            checks++;
            if (cpu_ready !== ((i % 3 == 2) && i <= 8)) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got=%b", i, cpu_ready);
            end
            if (cpu_ready === 1'b1 && k < 3) begin
                e = model(1'b0, qa[k], '0, cpu_pc);
                checks++;
                if ({cpu_err, cpu_rdata} !== {1'b0, e.rdata}) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got=%b/%h exp=0/%h",
                             k, cpu_err, cpu_rdata, e.rdata);
                end
                k++;
                if (k < 3) cpu_addr = qa[k];
                else cpu_req = 1'b0;
            end
        end
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=3", k);
        end
    endtask

    task automatic test_reset_mid();
        logic [167:0] outs;
        @(negedge clk);
        irq0      = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = T0;
        cpu_wdata = 32'h55;
        @(negedge clk);
        checks++;
        if (dev_we0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_we0 got=%b exp=1", dev_we0);
        end
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        outs = {cpu_ready, cpu_rdata, cpu_err, dev_we0, dev_we1,
                dev_addr, dev_wdata, dev_pc, hwint};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=0", outs);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({cpu_ready, dev_we0} !== 2'b00) begin
                errors++;
                $display("FAIL mid_reset_abort[%0d] got=%b exp=00",
                         i, {cpu_ready, dev_we0});
            end
        end
        checks++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL mid_reset_hwint got=%b exp=000001", hwint);
        end
        irq0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_irq();
        logic [5:0] exp;
        irq0 = 1'b0;
        irq1 = 1'b0;
        @(negedge clk);
        irq0 = 1'b1;
        checks++;
        if (hwint !== 6'b000000) begin
            errors++;
            $display("FAIL irq_lag got=%b exp=000000", hwint);
        end
        @(negedge clk);
        checks++;
        if (hwint !== 6'b000001) begin
            errors++;
            $display("FAIL irq0_set got=%b exp=000001", hwint);
        end
        irq1 = 1'b1;
        @(negedge clk);
        checks++;
        if (hwint !== 6'b000011) begin
            errors++;
            $display("FAIL irq_both got=%b exp=000011", hwint);
        end
        for (int i = 0; i < 10; i++) begin
            irq0 = 1'($urandom);
            irq1 = 1'($urandom);
            exp  = {4'b0000, irq1, irq0};
            @(negedge clk);
            checks++;
            if (hwint !== exp) begin
                errors++;
                $display("FAIL irq_rand[%0d] got=%b exp=%b", i, hwint, exp);
            end
        end
        irq0 = 1'b0;
        irq1 = 1'b0;
    endtask

    task automatic test_random();
        obs_t o;
        obs_t e;
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        we;
        int          r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0) base = T0;
            else if (r == 1) base = T1;
            else base = $urandom;
            a  = base + $urandom_range(0, 15);
            we = 1'($urandom);
            wd = $urandom;
            pc = $urandom;
            run_txn(we, a, wd, pc, o);
            e = model(we, a, wd, pc);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand[%0d] a=%h we=%b got=%h exp=%h",
                         i, a, we, o, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        key0 = $urandom;
        key1 = $urandom;
        test_reset();
        test_store_load();
        test_timer1_store();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_irq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dev_bridge.md
# dev_bridge

Initiator side of the memory-mapped device bus: accepts single load/store requests from the CPU core, decodes them onto one of two Timer-style responder ports, and returns read data with a completion/error flag. It also registers the responders' IRQ lines into the hardware interrupt vector consumed by CP0. It sits between the CPU data-memory stage and the timer devices.

## Interface

Parameters:

- T0_BASE, 32'h0000_7F00, word-aligned base of timer 0 window (3 words)
- T1_BASE, 32'h0000_7F10, word-aligned base of timer 1 window (3 words)

Ports:

- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-low; 0 at a posedge resets all state
- cpu_req  in  1  request valid, sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_pc  in  32  PC of the requesting instruction
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cpu_err  out  1  access fault, valid while cpu_ready=1
- dev_addr  out  30  word address [31:2] to devices
- dev_wdata  out  32  write data to devices
- dev_pc  out  32  PC forwarded to devices
- dev_we0  out  1  write strobe, timer 0
- dev_we1  out  1  write strobe, timer 1
- dev0_rdata  in  32  combinational read data, timer 0
- dev1_rdata  in  32  combinational read data, timer 1
- irq0  in  1  interrupt, timer 0
- irq1  in  1  interrupt, timer 1
- hwint  out  6  {4'b0, irq1, irq0}, registered

## Operation

- FSM states: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: if cpu_req=1, latch we/addr/wdata/pc, decode, go ACCESS; else stay.
- Decode (on latched address): offset = addr − base; hit if 0 ≤ offset ≤ 8 and addr[1:0]=0. Offset 0 = ctrl, 4 = preset, 8 = count.
- Fault (err=1) if: addr[1:0]≠0; address hits no window (includes base+0xC); store to count (offset 8).
- ACCESS (exactly one cycle): dev_addr/dev_wdata/dev_pc driven from latched values. Valid store: the selected dev_weN=1, the other 0. Valid load: selected devN_rdata sampled into the read register at the ACCESS→RESP edge. Faults assert no strobe; the read register loads 0. Go RESP.
- RESP (exactly one cycle): cpu_ready=1, cpu_rdata = read register (0 for stores and faults), cpu_err = fault flag. Go IDLE.
- cpu_req is ignored in ACCESS and RESP. A req held high through RESP is accepted as a new request in the following IDLE cycle.
- dev_weN are decoded from registered state only. They are never asserted outside ACCESS, and never both at once.
- hwint[1:0] ← {irq1, irq0} every cycle; hwint[5:2] = 0.

## Timing

- Request accepted at posedge E0 (IDLE, cpu_req=1). ACCESS occupies E0–E1, so the device write happens at E1. RESP occupies E1–E2, with cpu_ready high between E1 and E2. Next acceptance is no earlier than E3.
- Throughput: one access per 3 cycles.
- Load latency: device read data captured at E1 and presented at E1–E2.
- hwint lags irq by one cycle.
- Reset values: cpu_ready=0, cpu_rdata=0, cpu_err=0, dev_we0=0, dev_we1=0, dev_addr=0, dev_wdata=0, dev_pc=0, hwint=0; state IDLE; latches 0.
- Reset mid-operation (ACCESS or RESP): the next state is IDLE. No strobe or ready is issued after the reset edge, and the aborted access is never completed.
- Reset and cpu_req in the same cycle: reset wins, and the request is dropped.

## Test plan

- Store 0x0000_0009 to 0x7F00, then load 0x7F00: dev_we0 pulses for 1 cycle with dev_addr=0x1FC0 and dev_wdata=9; the load returns cpu_rdata=dev0_rdata, cpu_err=0; cpu_ready fires 2 cycles after each acceptance.
- Store 0x64 to 0x7F14: only dev_we1 pulses, with dev_addr=0x1FC5; dev_we0 stays 0 throughout.
- Faults: store to 0x7F08, load 0x7F0C, load 0x7F02, load 0x3000 → no strobe, cpu_ready=1, cpu_err=1, cpu_rdata=0 each.
- Back-to-back: cpu_req held high with 3 loads queued → cpu_ready pulses exactly every 3 cycles, each returning data from its own address.
- Drive reset=0 during ACCESS of a store → dev_we0 is low after that edge, and cpu_ready never pulses for that access. All outputs are 0 at the reset edge, and hwint=0 even with irq0=1 held.
- irq0 0→1 at cycle N → hwint=6'b000001 from cycle N+1. With irq1 also high, hwint=6'b000011, and bits [5:2] always read 0.
